// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the handshaked sequential ALU.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        CMD_RXOR  = 3'b000,
        CMD_SHIFT = 3'b001,
        CMD_PASS  = 3'b010,
        CMD_XOR   = 3'b011,
        CMD_SET   = 3'b100,
        CMD_AND   = 3'b101,
        CMD_SUB   = 3'b110,
        CMD_MUL   = 3'b111
    } alu_cmd_e;

    typedef enum logic [1:0] {
        SH_SHL = 2'b00,
        SH_SHR = 2'b01,
        SH_RCL = 2'b10,
        SH_RCR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } alu_state_e;

    // req_mode bit selecting carry-in for SUB
    localparam int unsigned SUB_USE_CARRY = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response channel of alu_seq plus the architectural carry controls.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_cmd;
    logic [1:0]       req_mode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_imm;
    logic             carry_clr;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rslt;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_pari;
    logic             rsp_err;
    logic             carry_q;

    modport master (
        output req_valid, req_cmd, req_mode, req_a, req_b, req_imm, carry_clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_rslt, rsp_hi, rsp_carry, rsp_zero, rsp_pari,
               rsp_err, carry_q
    );

    modport slave (
        input  req_valid, req_cmd, req_mode, req_a, req_b, req_imm, carry_clr, rsp_ready,
        output req_ready, rsp_valid, rsp_rslt, rsp_hi, rsp_carry, rsp_zero, rsp_pari,
               rsp_err, carry_q
    );

endinterface

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;

    // Outputs show the product after the current step, so done lines up with the last step.
    always_comb begin
        w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        {w_acc_nxt, w_mplier_nxt} = {w_sum, r_mplier[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= CW'(WIDTH);
        end else if (r_cnt != '0) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == CW'(1));
    assign o_hi   = w_acc_nxt;
    assign o_lo   = w_mplier_nxt;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with architectural carry and iterative shifts.
// Define ALU_SEQ_MUL_EN to make cmd 111 a shift-add multiply; otherwise it reports rsp_err.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_state_e       r_state;
    alu_cmd_e         r_cmd;
    shift_mode_e      r_mode;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic             r_c;
    logic             r_carry_q;
    logic [WIDTH-1:0] r_rslt;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_zero;
    logic             r_pari;
    logic             r_err;

    alu_cmd_e         w_cmd;
    shift_mode_e      w_mode;
    logic             w_accept;
    logic             w_cin;
    logic             w_long;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_s_rslt;
    logic             w_s_carry;
    logic             w_s_err;
    logic             w_s_upd;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_c_nxt;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic             w_fin;
    logic [WIDTH-1:0] w_fin_rslt;
    logic [WIDTH-1:0] w_fin_hi;
    logic             w_fin_carry;
    logic             w_fin_err;
    logic             w_fin_upd;

    assign w_cmd    = alu_cmd_e'(bus.req_cmd);
    assign w_mode   = shift_mode_e'(bus.req_mode);
    assign w_accept = bus.req_valid && (r_state == ST_IDLE);
    // A clear coinciding with accept must already be visible to the accepted op.
    assign w_cin    = bus.carry_clr ? 1'b0 : r_carry_q;
    assign w_long   = ((w_cmd == CMD_SHIFT) && (w_amt != '0)) || ((w_cmd == CMD_MUL) && MUL_EN);
    assign w_sub    = {1'b0, bus.req_a} - {1'b0, bus.req_b}
                    + {{WIDTH{1'b0}}, bus.req_mode[SUB_USE_CARRY] & w_cin};

    always_comb begin
        w_amt = '0;
        for (int unsigned i = 0; i < SHW; i++) begin
            if (i < 4) w_amt[i] = bus.req_imm[i];
        end
    end

    always_comb begin
        w_s_rslt  = bus.req_a;
        w_s_carry = 1'b0;
        w_s_err   = 1'b0;
        w_s_upd   = 1'b0;
        case (w_cmd)
            CMD_RXOR:  begin w_s_rslt = '0; w_s_rslt[0] = ^bus.req_a; end
            CMD_SHIFT: begin w_s_carry = w_cin; w_s_upd = 1'b1; end
            CMD_PASS:  ;
            CMD_XOR:   w_s_rslt = bus.req_a ^ bus.req_b;
            CMD_SET:   w_s_rslt[3:0] = bus.req_imm;
            CMD_AND:   w_s_rslt = bus.req_a & bus.req_b;
            CMD_SUB:   begin w_s_rslt = w_sub[WIDTH-1:0]; w_s_carry = w_sub[WIDTH]; w_s_upd = 1'b1; end
            CMD_MUL:   w_s_err = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        w_sh_nxt = r_sh;
        w_c_nxt  = r_c;
        case (r_mode)
            SH_SHL: begin w_c_nxt = r_sh[WIDTH-1]; w_sh_nxt = r_sh << 1; end
            SH_SHR: begin w_c_nxt = r_sh[0];       w_sh_nxt = r_sh >> 1; end
            SH_RCL: begin w_c_nxt = r_sh[WIDTH-1]; w_sh_nxt = {r_sh[WIDTH-2:0], r_c}; end
            SH_RCR: begin w_c_nxt = r_sh[0];       w_sh_nxt = {r_c, r_sh[WIDTH-1:1]}; end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && (w_cmd == CMD_MUL)),
        .i_a     (bus.req_a),
        .i_b     (bus.req_b),
        .o_done  (w_mul_done),
        .o_hi    (w_mul_hi),
        .o_lo    (w_mul_lo)
    );
`else
    assign w_mul_done = 1'b0;
    assign w_mul_hi   = '0;
    assign w_mul_lo   = '0;
`endif

    // Single completion path: single-cycle ops finish from IDLE, iterative ops from BUSY.
    always_comb begin
        w_fin       = 1'b0;
        w_fin_rslt  = w_s_rslt;
        w_fin_hi    = '0;
        w_fin_carry = w_s_carry;
        w_fin_err   = w_s_err;
        w_fin_upd   = w_s_upd;
        case (r_state)
            ST_IDLE: w_fin = w_accept && !w_long;
            ST_BUSY: begin
                w_fin_err = 1'b0;
                w_fin_upd = 1'b1;
                if (r_cmd == CMD_MUL) begin
                    w_fin       = w_mul_done;
                    w_fin_rslt  = w_mul_lo;
                    w_fin_hi    = w_mul_hi;
                    w_fin_carry = |w_mul_hi;
                end else begin
                    w_fin       = (r_cnt == SHW'(1));
                    w_fin_rslt  = w_sh_nxt;
                    w_fin_carry = w_c_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cmd     <= CMD_RXOR;
            r_mode    <= SH_SHL;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_c       <= 1'b0;
            r_carry_q <= 1'b0;
            r_rslt    <= '0;
            r_hi      <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_pari    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && bus.carry_clr) r_carry_q <= 1'b0;
            if (w_accept) begin
                r_cmd  <= w_cmd;
                r_mode <= w_mode;
                r_sh   <= bus.req_a;
                r_c    <= w_cin;
                r_cnt  <= w_amt;
            end
            if (r_state == ST_BUSY) begin
                r_sh  <= w_sh_nxt;
                r_c   <= w_c_nxt;
                r_cnt <= r_cnt - SHW'(1);
            end
            if (w_fin) begin
                r_rslt  <= w_fin_rslt;
                r_hi    <= w_fin_hi;
                r_carry <= w_fin_carry;
                r_err   <= w_fin_err;
                r_zero  <= (w_fin_rslt == '0);
                r_pari  <= ^w_fin_rslt;
                if (w_fin_upd) r_carry_q <= w_fin_carry;
            end
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= w_long ? ST_BUSY : ST_DONE;
                ST_BUSY: if (w_fin) r_state <= ST_DONE;
                ST_DONE: if (bus.rsp_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_DONE);
    assign bus.rsp_rslt  = r_rslt;
    assign bus.rsp_hi    = r_hi;
    assign bus.rsp_carry = r_carry;
    assign bus.rsp_zero  = r_zero;
    assign bus.rsp_pari  = r_pari;
    assign bus.rsp_err   = r_err;
    assign bus.carry_q   = r_carry_q;

endmodule
